// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter blocks.
//   N_REQ    : number of requesters sharing the output channel
//   W_DEF    : default data width per requester
//   req_id_t : requester index type (pointer, winner, output id)
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int W_DEF = 4;

  typedef logic [1:0] req_id_t;

endpackage : rr_arb_pkg

// File: rtl/mux_4_1_rr_arbiter_if.sv
// Bundle of the requester-side and consumer-side handshake signals.
//   in_valid/in_data/in_ready    : four valid/ready requesters, requester i at in_data[i*W +: W]
//   out_valid/out_data/out_id/out_ready : single consumer channel
// Modports: slave = arbiter side, master = producers/consumer side.
interface mux_4_1_rr_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int W = W_DEF
);

  logic [N_REQ-1:0]   in_valid;
  logic [N_REQ*W-1:0] in_data;
  logic [N_REQ-1:0]   in_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  req_id_t            out_id;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );

endinterface : mux_4_1_rr_arbiter_if

// File: rtl/mux_4_1_rr_arbiter_rr_pick_4.sv
// Combinational round-robin pick over four requesters.
//   in_valid  : request vector
//   ptr       : index granted last; search starts at ptr+1 and ends at ptr
//   winner    : first valid index in search order (ptr when nothing is valid)
//   any_valid : at least one request present
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_valid,
  input  req_id_t          ptr,
  output req_id_t          winner,
  output logic             any_valid
);

  req_id_t idx_s;

  // Scan from the lowest priority (ptr itself) up to ptr+1 so the
  // highest-priority valid requester is the last one written.
  always_comb begin
    winner    = ptr;
    any_valid = |in_valid;
    idx_s     = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s = ptr + req_id_t'(k);
      if (in_valid[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule : rr_pick_4

// File: rtl/mux_4_1_rr_arbiter.sv
// Four-way round-robin arbiter feeding a one-entry output register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears output, ptr -> 3)
//   bus  : slave modport; requesters on in_*, consumer on out_*
// One word per cycle is accepted whenever the output register is empty or
// draining; the output is fully registered (no in_data -> out_data path).
module mux_4_1_rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int W = W_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  mux_4_1_rr_arbiter_if.slave     bus
);

  logic             load_s;
  logic             any_valid_s;
  req_id_t          winner_s;
  logic [W-1:0]     sel_data_s;
  logic [N_REQ-1:0] in_ready_s;

  logic             out_valid_r;
  logic [W-1:0]     out_data_r;
  req_id_t          out_id_r;
  req_id_t          ptr_r;

  rr_pick_4 u_pick (
    .in_valid  (bus.in_valid),
    .ptr       (ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Output register can take a word when empty or being drained this cycle.
  assign load_s = !out_valid_r || bus.out_ready;

  // Grant the winner only when the register can load; nothing during reset.
  always_comb begin
    in_ready_s = {N_REQ{1'b0}};
    if (load_s && any_valid_s && !rst) begin
      in_ready_s[winner_s] = 1'b1;
    end else begin
      in_ready_s = {N_REQ{1'b0}};
    end
  end

  // 4:1 data select indexed by the current winner.
  always_comb begin
    case (winner_s)
      2'd0:    sel_data_s = bus.in_data[0*W +: W];
      2'd1:    sel_data_s = bus.in_data[1*W +: W];
      2'd2:    sel_data_s = bus.in_data[2*W +: W];
      2'd3:    sel_data_s = bus.in_data[3*W +: W];
      default: sel_data_s = {W{1'b0}};
    endcase
  end

  // Output register and last-grant pointer; both freeze under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_id_r    <= 2'd0;
      ptr_r       <= 2'd3;
    end else if (load_s) begin
      out_valid_r <= any_valid_s;
      if (any_valid_s) begin
        out_data_r <= sel_data_s;
        out_id_r   <= winner_s;
        ptr_r      <= winner_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;

endmodule : mux_4_1_rr_arbiter

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed self-checking bench for mux_4_1_rr_arbiter.
module tb_mux_4_1_rr_arbiter;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mux_4_1_rr_arbiter_if #(.W(4)) bus ();

  mux_4_1_rr_arbiter #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] ALL_DATA = {4'hD, 4'hC, 4'hB, 4'hA};

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = ALL_DATA;
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    bus.in_valid = 4'b0000;
    rst = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 4'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    tests++; if (bus.out_id !== 2'd0) begin fails++; $display("FAIL reset_out_id: got %0d want 0", bus.out_id); end
    tests++; if (dut.ptr_r !== 2'd3) begin fails++; $display("FAIL reset_ptr: got %0d want 3", dut.ptr_r); end
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.in_valid  = 4'b0100;
    bus.in_data   = 16'h0900;
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 4'b0100) begin fails++; $display("FAIL single_in_ready: got %b want 0100", bus.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    tests++; if (bus.out_data !== 4'h9) begin fails++; $display("FAIL single_out_data: got %h want 9", bus.out_data); end
    tests++; if (bus.out_id !== 2'd2) begin fails++; $display("FAIL single_out_id: got %0d want 2", bus.out_id); end
    tests++; if (dut.ptr_r !== 2'd2) begin fails++; $display("FAIL single_ptr: got %0d want 2", dut.ptr_r); end
    @(negedge clk);
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_rotation();
    logic [1:0] exp_id   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] exp_data [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB, 4'hC, 4'hD};
    logic [3:0] exp_rdy  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    test_reset();
    @(negedge clk);
    bus.in_valid  = 4'b1111;
    bus.in_data   = ALL_DATA;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++; if (bus.in_ready !== exp_rdy[i]) begin fails++; $display("FAIL rot_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_rdy[i]); end
      @(posedge clk); #1;
      tests++; if (bus.out_id !== exp_id[i] || bus.out_data !== exp_data[i] || bus.out_valid !== 1'b1)
        begin fails++; $display("FAIL rot_out[%0d]: got v%b id%0d d%h want v1 id%0d d%h", i, bus.out_valid, bus.out_id, bus.out_data, exp_id[i], exp_data[i]); end
      @(negedge clk);
    end
  endtask

  // Entered with output holding id 3 / data D, all four requesters valid.
  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, bus.in_ready); end
      @(posedge clk); #1;
      tests++; if (bus.out_id !== 2'd3 || bus.out_data !== 4'hD || dut.ptr_r !== 2'd3)
        begin fails++; $display("FAIL bp_frozen[%0d]: got id%0d d%h ptr%0d want id3 dD ptr3", i, bus.out_id, bus.out_data, dut.ptr_r); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL bp_release_ready: got %b want 0001", bus.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus.out_id !== 2'd0 || bus.out_data !== 4'hA)
      begin fails++; $display("FAIL bp_release_out: got id%0d d%h want id0 dA", bus.out_id, bus.out_data); end
    @(negedge clk);
  endtask

  // Entered with ptr = 0.
  task automatic test_sparse();
    logic [3:0] vec     [5] = '{4'b0010, 4'b0001, 4'b0011, 4'b0011, 4'b0001};
    logic [1:0] exp_id  [5] = '{2'd1,    2'd0,    2'd1,    2'd0,    2'd0};
    logic [3:0] exp_d   [5] = '{4'hB,    4'hA,    4'hB,    4'hA,    4'hA};
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = vec[i];
      @(posedge clk); #1;
      tests++; if (bus.out_id !== exp_id[i] || bus.out_data !== exp_d[i] || dut.ptr_r !== exp_id[i])
        begin fails++; $display("FAIL sparse[%0d]: got id%0d d%h ptr%0d want id%0d d%h", i, bus.out_id, bus.out_data, dut.ptr_r, exp_id[i], exp_d[i]); end
      @(negedge clk);
    end
  endtask

  // Entered with ptr = 0, last word id 0 / data A.
  task automatic test_idle();
    logic [1:0] exp_id [3] = '{2'd1, 2'd2, 2'd3};
    logic [3:0] exp_d  [3] = '{4'hB, 4'hC, 4'hD};
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++; if (bus.out_valid !== 1'b0 || dut.ptr_r !== 2'd0 || bus.out_id !== 2'd0)
        begin fails++; $display("FAIL idle[%0d]: got v%b ptr%0d id%0d want v0 ptr0 id0", i, bus.out_valid, dut.ptr_r, bus.out_id); end
      @(negedge clk);
    end
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id[i] || bus.out_data !== exp_d[i])
        begin fails++; $display("FAIL resume[%0d]: got v%b id%0d d%h want v1 id%0d d%h", i, bus.out_valid, bus.out_id, bus.out_data, exp_id[i], exp_d[i]); end
      @(negedge clk);
    end
  endtask

  // Entered with out_valid = 1, out_id = 3, all requesters valid.
  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL midrst_in_ready: got %b want 0000", bus.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_id !== 2'd0)
      begin fails++; $display("FAIL midrst_out: got v%b d%h id%0d want v0 d0 id0", bus.out_valid, bus.out_data, bus.out_id); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL midrst_first_ready: got %b want 0001", bus.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== 4'hA)
      begin fails++; $display("FAIL midrst_first_out: got v%b id%0d d%h want v1 id0 dA", bus.out_valid, bus.out_id, bus.out_data); end
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 4'b0000;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_back_pressure();
    test_sparse();
    test_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mux_4_1_rr_arbiter

// File: doc/mux_4_1_rr_arbiter.md
# mux_4_1_rr_arbiter

Round-robin arbiter that shares one 4-bit output channel among four valid/ready requesters. Each cycle it picks one requester in rotating priority, routes that requester's data through a 4:1 select, and holds the result in a one-entry output register. It sits between four independent 4-bit producers and a single consumer. It sustains one transfer per cycle with fair service under full load.

## Interface

Parameters
- W, 4, data width per requester and at the output.

Ports
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  bit i: requester i presents data.
- in_data  input  4*W  requester i occupies bits [i*W +: W].
- in_ready  output  4  bit i: requester i's word is taken this cycle. One-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  W  held word.
- out_id  output  2  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation

- load = !out_valid | out_ready. This is the output register's free-or-draining condition.
- ptr (2 bits) is the last granted index.
- Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). winner is the first index in that order with in_valid set. any_valid = |in_valid.
- in_ready[i] = load & any_valid & (winner == i).
  - This is combinational from in_valid, out_valid, out_ready and ptr.
  - in_ready is never asserted for a requester with in_valid low.
- On a clock edge with load high:
  - out_valid <= any_valid.
  - If any_valid: out_data <= in_data[winner], out_id <= winner, ptr <= winner.
  - If !any_valid: out_data, out_id and ptr hold.
- On a clock edge with load low:
  - All state holds.
  - in_ready = 0, so a requester's word is never dropped.
- Requester transfer occurs when in_valid[i] & in_ready[i]. Output transfer occurs when out_valid & out_ready.
- Requesters hold in_valid and in_data stable until they are accepted. Deasserting in_valid before acceptance is allowed; that requester is simply skipped.
- Fairness: with all four requesters continuously valid and out_ready = 1, grants follow 0,1,2,3,0,… A requester waits at most 3 other grants.
- Reset: out_valid = 0, out_data = 0, out_id = 0, ptr = 3, so requester 0 has first priority after reset.
- Reset mid-operation discards any held output word; in_ready = 0 during the reset cycle.

## Timing

- Latency is 1 cycle: data accepted at edge k appears on out_data/out_valid after edge k.
- Throughput is 1 word/cycle while out_ready stays high.
- Back-pressure: while out_valid & !out_ready, all in_ready = 0. Data, id and ptr are frozen.
- Simultaneous drain and refill: with out_valid & out_ready and any_valid, the new word is loaded in the same edge. There is no bubble.
- Single requester with ptr equal to its own index: it is still granted, because it is the last in search order. There is no starvation of a lone requester.
- Pointer wrap: 3 → 0 via mod-4 arithmetic. ptr never takes a value outside 0..3.
- No combinational path from in_data to out_data; the output is fully registered.

## Structure

- Shared package rr_arb_pkg holds:
  - localparam N_REQ = 4.
  - typedef logic [1:0] req_id_t, used for ptr, winner and out_id.
- Sub-module rr_pick_4 is combinational.
  - Inputs: in_valid[3:0] and ptr.
  - Outputs: winner (req_id_t) and any_valid.
  - It is reusable by other round-robin blocks.
- The top level contains the 4:1 data select indexed by winner, the output register, and the ptr register.

## Test plan

- Reset then single requester: in_valid = 4'b0100, data2 = 4'h9, out_ready = 1.
  - Expect in_ready = 4'b0100 in the first cycle.
  - Next cycle: out_valid = 1, out_data = 9, out_id = 2, ptr = 2.
- Full load rotation: all valid, data i = 4'hA+i, out_ready = 1 for 8 cycles.
  - Expect out_id sequence 0,1,2,3,0,1,2,3 with out_data A,B,C,D,A,B,C,D.
- Back-pressure: out_ready = 0 with the output full and all valid for 3 cycles.
  - Expect in_ready = 0 and out_data/out_id frozen.
  - On out_ready = 1, expect the next id in rotation with no skip or duplicate.
- Sparse requests: ptr = 1, in_valid = 4'b0001.
  - Expect grant 0, showing wrap past 2 and 3.
  - Then in_valid = 4'b0011: expect grant 1 before 0.
- Idle gap: in_valid = 0 for 2 cycles with out_ready = 1.
  - Expect out_valid = 0 and ptr unchanged.
  - Resume with all valid: rotation continues from ptr+1.
- Reset mid-stream: assert rst while out_valid = 1, out_id = 3.
  - Expect out_valid = 0, out_data = 0, out_id = 0 next cycle.
  - First grant after release goes to requester 0.
